// File: rtl/core_bus_arbiter.sv
// ============================================================================
// Module   : core_bus_arbiter
// Purpose  : Shares the core's single memory bus between instruction fetch
//            and data load/store. Each port queues one single-beat word
//            request; one owner holds the bus at a time. Default policy is
//            data priority with a starvation limit on fetch (MAX_DATA_RUN).
//            Define CORE_ARB_RR_EN to use round-robin between the two ports
//            instead; MAX_DATA_RUN is then ignored.
// Ports    : clk, rst                  - clock, async active-high reset
//            i_fetch_start/addr        - fetch request pulse + word address
//            o_fetch_ready/data        - fetch completion pulse + read data
//            i_data_start/write/addr/wr- load/store request pulse + fields
//            o_data_ready/rd           - load/store completion + read data
//            o_bus_start/write/addr/data_wr - bus transaction (registered)
//            i_bus_ready/data_rd       - bus completion pulse + read data
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_bus_arbiter #(
  parameter int MAX_DATA_RUN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_fetch_start,
  input  logic [29:0] i_fetch_addr,
  output logic        o_fetch_ready,
  output logic [31:0] o_fetch_data,
  input  logic        i_data_start,
  input  logic        i_data_write,
  input  logic [29:0] i_data_addr,
  input  logic [31:0] i_data_wr,
  output logic        o_data_ready,
  output logic [31:0] o_data_rd,
  output logic        o_bus_start,
  output logic        o_bus_write,
  output logic [29:0] o_bus_addr,
  output logic [31:0] o_bus_data_wr,
  input  logic        i_bus_ready,
  input  logic [31:0] i_bus_data_rd
);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_GRANT_FETCH = 2'd1,
    ST_GRANT_DATA  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  // Pending bits stay set while the port owns the bus and clear on its ready.
  logic        r_f_pend;
  logic [29:0] r_f_addr;
  logic        r_d_pend;
  logic        r_d_write;
  logic [29:0] r_d_addr;
  logic [31:0] r_d_wdata;

  logic        r_bus_start;
  logic        r_bus_write;
  logic [29:0] r_bus_addr;
  logic [31:0] r_bus_wdata;

  logic        w_f_done;
  logic        w_d_done;
  logic        w_f_acc;
  logic        w_d_acc;
  logic        w_f_req;
  logic        w_d_req;
  logic        w_arb;
  logic        w_pick_fetch;
  logic        w_grant_f;
  logic        w_grant_d;
  logic [29:0] w_f_addr_eff;
  logic        w_d_write_eff;
  logic [29:0] w_d_addr_eff;
  logic [31:0] w_d_wdata_eff;

  assign w_f_done = (r_state == ST_GRANT_FETCH) && i_bus_ready;
  assign w_d_done = (r_state == ST_GRANT_DATA)  && i_bus_ready;

  // A start is taken when the port is free, or when its current transaction
  // completes in this same cycle.
  assign w_f_acc = i_fetch_start && (!r_f_pend || w_f_done);
  assign w_d_acc = i_data_start  && (!r_d_pend || w_d_done);

  // Outstanding request after this cycle, including one arriving now.
  assign w_f_req = w_f_acc || (r_f_pend && !w_f_done);
  assign w_d_req = w_d_acc || (r_d_pend && !w_d_done);

  // Decision points: idle bus, or the owner's completion cycle (bus_ready
  // outside a grant state only reaches here through ST_IDLE, where it is
  // ignored by the done terms above).
  assign w_arb = (r_state == ST_IDLE) || i_bus_ready;

  // A request arriving this cycle bypasses its latch so it can be granted
  // with zero added latency.
  assign w_f_addr_eff  = w_f_acc ? i_fetch_addr : r_f_addr;
  assign w_d_write_eff = w_d_acc ? i_data_write : r_d_write;
  assign w_d_addr_eff  = w_d_acc ? i_data_addr  : r_d_addr;
  assign w_d_wdata_eff = w_d_acc ? i_data_wr    : r_d_wdata;

`ifdef CORE_ARB_RR_EN
  logic r_last_data;

  // On contention, hand the bus to whichever port did not have it last.
  assign w_pick_fetch = r_last_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_data <= 1'b0;
    end else if (w_grant_f) begin
      r_last_data <= 1'b0;
    end else if (w_grant_d) begin
      r_last_data <= 1'b1;
    end
  end
`else
  localparam logic [3:0] c_MAX_RUN = 4'(MAX_DATA_RUN);

  logic [3:0] r_run_cnt;

  // Data wins contention until it has taken c_MAX_RUN grants in a row
  // against a waiting fetch.
  assign w_pick_fetch = (r_run_cnt == c_MAX_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run_cnt <= 4'd0;
    end else if (!w_f_req || w_grant_f) begin
      r_run_cnt <= 4'd0;
    end else if (w_grant_d && (r_run_cnt != c_MAX_RUN)) begin
      r_run_cnt <= r_run_cnt + 4'd1;
    end
  end
`endif

  // Next-state and grant decision.
  always_comb begin
    w_state_next = r_state;
    w_grant_f    = 1'b0;
    w_grant_d    = 1'b0;
    if (w_arb) begin
      w_state_next = ST_IDLE;
      if (w_f_req && w_d_req) begin
        w_grant_f = w_pick_fetch;
        w_grant_d = !w_pick_fetch;
      end else begin
        w_grant_f = w_f_req;
        w_grant_d = w_d_req;
      end
      if (w_grant_f) begin
        w_state_next = ST_GRANT_FETCH;
      end else if (w_grant_d) begin
        w_state_next = ST_GRANT_DATA;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Per-port request latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f_pend  <= 1'b0;
      r_f_addr  <= 30'd0;
      r_d_pend  <= 1'b0;
      r_d_write <= 1'b0;
      r_d_addr  <= 30'd0;
      r_d_wdata <= 32'd0;
    end else begin
      r_f_pend <= w_f_req;
      r_d_pend <= w_d_req;
      if (w_f_acc) begin
        r_f_addr <= i_fetch_addr;
      end
      if (w_d_acc) begin
        r_d_write <= i_data_write;
        r_d_addr  <= i_data_addr;
        r_d_wdata <= i_data_wr;
      end
    end
  end

  // Registered bus side: start pulses once, fields hold until next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus_start <= 1'b0;
      r_bus_write <= 1'b0;
      r_bus_addr  <= 30'd0;
      r_bus_wdata <= 32'd0;
    end else begin
      r_bus_start <= w_grant_f || w_grant_d;
      if (w_grant_f) begin
        r_bus_write <= 1'b0;
        r_bus_addr  <= w_f_addr_eff;
        r_bus_wdata <= 32'd0;
      end else if (w_grant_d) begin
        r_bus_write <= w_d_write_eff;
        r_bus_addr  <= w_d_addr_eff;
        r_bus_wdata <= w_d_wdata_eff;
      end
    end
  end

  assign o_bus_start   = r_bus_start;
  assign o_bus_write   = r_bus_write;
  assign o_bus_addr    = r_bus_addr;
  assign o_bus_data_wr = r_bus_wdata;

  assign o_fetch_ready = w_f_done;
  assign o_data_ready  = w_d_done;
  assign o_fetch_data  = i_bus_data_rd;
  assign o_data_rd     = i_bus_data_rd;

endmodule

`default_nettype wire

// File: tb/tb_core_bus_arbiter.sv
// ============================================================================
// Module   : tb_core_bus_arbiter
// Purpose  : Self-checking bench for core_bus_arbiter. A transaction-level
//            model (one request slot per port, current owner, data streak)
//            predicts every output each cycle; directed scenarios add
//            explicit checks against fixed values.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_bus_arbiter;

  localparam int MAX_RUN = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        fs;
  logic [29:0] fa;
  logic        f_rdy;
  logic [31:0] f_data;
  logic        ds;
  logic        dw;
  logic [29:0] da;
  logic [31:0] dwd;
  logic        d_rdy;
  logic [31:0] d_rd;
  logic        b_start;
  logic        b_write;
  logic [29:0] b_addr;
  logic [31:0] b_wdata;
  logic        br;
  logic [31:0] brd;

  core_bus_arbiter #(.MAX_DATA_RUN(MAX_RUN)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_fetch_start (fs),
    .i_fetch_addr  (fa),
    .o_fetch_ready (f_rdy),
    .o_fetch_data  (f_data),
    .i_data_start  (ds),
    .i_data_write  (dw),
    .i_data_addr   (da),
    .i_data_wr     (dwd),
    .o_data_ready  (d_rdy),
    .o_data_rd     (d_rd),
    .o_bus_start   (b_start),
    .o_bus_write   (b_write),
    .o_bus_addr    (b_addr),
    .o_bus_data_wr (b_wdata),
    .i_bus_ready   (br),
    .i_bus_data_rd (brd)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [29:0] glog[$];

  // Reference model: owner 0 = none, 1 = fetch, 2 = data.
  bit          mf_has;
  logic [29:0] mf_addr;
  bit          md_has;
  bit          md_wr;
  logic [29:0] md_addr;
  logic [31:0] md_wd;
  int          m_owner;
  int          m_streak;
  bit          m_last_data;
  bit          exp_start;
  bit          exp_write;
  logic [29:0] exp_addr;
  logic [31:0] exp_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mf_has = 0; mf_addr = '0; md_has = 0; md_wr = 0; md_addr = '0; md_wd = '0;
    m_owner = 0; m_streak = 0; m_last_data = 0;
    exp_start = 0; exp_write = 0; exp_addr = '0; exp_wd = '0;
  endtask

  task automatic drive(input logic f_s, input logic [29:0] f_a, input logic d_s,
                       input logic d_w, input logic [29:0] d_a, input logic [31:0] d_wd,
                       input logic b_r, input logic [31:0] b_rd);
    fs = f_s; fa = f_a; ds = d_s; dw = d_w; da = d_a; dwd = d_wd; br = b_r; brd = b_rd;
  endtask

  task automatic quiet();
    drive(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0, 32'd0);
  endtask

  // Mid-cycle: compare every output with the model.
  task automatic settle();
    @(negedge clk);
    chk("bus_start", 32'(b_start), 32'(exp_start));
    chk("bus_write", 32'(b_write), 32'(exp_write));
    chk("bus_addr", 32'(b_addr), 32'(exp_addr));
    chk("bus_data_wr", b_wdata, exp_wd);
    chk("fetch_ready", 32'(f_rdy), 32'((m_owner == 1) && br));
    chk("data_ready", 32'(d_rdy), 32'((m_owner == 2) && br));
    chk("fetch_data", f_data, brd);
    chk("data_rd", d_rd, brd);
    if (b_start) glog.push_back(b_addr);
  endtask

  // Apply the arbitration rules to this cycle's inputs, then cross the edge.
  task automatic adv();
    bit pick_data;
    if (br && m_owner == 1) begin mf_has = 0; m_owner = 0; end
    if (br && m_owner == 2) begin md_has = 0; m_owner = 0; end
    if (fs && !mf_has) begin mf_has = 1; mf_addr = fa; end
    if (ds && !md_has) begin md_has = 1; md_wr = dw; md_addr = da; md_wd = dwd; end
    exp_start = 0;
    if (m_owner == 0 && (mf_has || md_has)) begin
      if (mf_has && md_has) begin
`ifdef CORE_ARB_RR_EN
        pick_data = !m_last_data;
`else
        pick_data = (m_streak != MAX_RUN);
`endif
      end else begin
        pick_data = md_has;
      end
      exp_start = 1;
      if (pick_data) begin
        m_owner = 2; m_last_data = 1;
        exp_write = md_wr; exp_addr = md_addr; exp_wd = md_wd;
        if (mf_has && m_streak < MAX_RUN) m_streak++;
      end else begin
        m_owner = 1; m_last_data = 0; m_streak = 0;
        exp_write = 0; exp_addr = mf_addr; exp_wd = 32'd0;
      end
    end
    if (!mf_has) m_streak = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    settle();
    adv();
  endtask

  initial begin
    logic [29:0] exp3[7];
    int issued;
    bit ok;

    rst = 1'b1;
    quiet();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_start", 32'(b_start), 32'd0);
    chk("rst_bus_addr", 32'(b_addr), 32'd0);
    chk("rst_bus_write", 32'(b_write), 32'd0);
    chk("rst_bus_data_wr", b_wdata, 32'd0);
    chk("rst_fetch_ready", 32'(f_rdy), 32'd0);
    chk("rst_data_ready", 32'(d_rdy), 32'd0);
    rst = 1'b0;
    quiet();
    cyc();

    // Single fetch, completed on the same cycle as bus_start.
    drive(1'b1, 30'h100, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0, 32'd0);
    cyc();
    drive(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b1, 32'hE3A00001);
    settle();
    chk("t1_bus_start", 32'(b_start), 32'd1);
    chk("t1_bus_addr", 32'(b_addr), 32'h100);
    chk("t1_bus_write", 32'(b_write), 32'd0);
    chk("t1_fetch_ready", 32'(f_rdy), 32'd1);
    chk("t1_fetch_data", f_data, 32'hE3A00001);
    adv();
    quiet();
    cyc();

    // Collision: data first, fetch right after data completes.
    drive(1'b1, 30'h104, 1'b1, 1'b1, 30'h40, 32'hDEADBEEF, 1'b0, 32'd0);
    cyc();
    quiet();
    settle();
    chk("t2_data_start", 32'(b_start), 32'd1);
    chk("t2_data_write", 32'(b_write), 32'd1);
    chk("t2_data_addr", 32'(b_addr), 32'h40);
    chk("t2_data_wdata", b_wdata, 32'hDEADBEEF);
    adv();
    drive(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b1, 32'h11111111);
    settle();
    chk("t2_data_ready", 32'(d_rdy), 32'd1);
    chk("t2_fetch_ready_low", 32'(f_rdy), 32'd0);
    adv();
    quiet();
    settle();
    chk("t2_fetch_start", 32'(b_start), 32'd1);
    chk("t2_fetch_addr", 32'(b_addr), 32'h104);
    chk("t2_fetch_write", 32'(b_write), 32'd0);
    adv();
    drive(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b1, 32'h22222222);
    cyc();
    quiet();
    cyc();

    // Starvation: fetch waits while data keeps re-requesting back to back.
`ifdef CORE_ARB_RR_EN
    exp3 = '{30'h300, 30'h200, 30'h301, 30'h302, 30'h303, 30'h304, 30'h305};
`else
    exp3 = '{30'h300, 30'h301, 30'h302, 30'h303, 30'h200, 30'h304, 30'h305};
`endif
    glog.delete();
    drive(1'b1, 30'h200, 1'b1, 1'b0, 30'h300, 32'd0, 1'b0, 32'd0);
    cyc();
    issued = 1;
    for (int c = 0; c < 40 && glog.size() < 7; c++) begin
      ok = (issued < 6) && (!md_has || m_owner == 2);
      drive(1'b0, 30'd0, ok, 1'b0, 30'(30'h300 + issued), 32'd0, 1'b1, $urandom);
      cyc();
      if (ok) issued++;
    end
    quiet();
    cyc();
    chk("t3_grant_count", 32'(glog.size()), 32'd7);
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("t3_grant%0d", k), 32'((k < glog.size()) ? glog[k] : 30'h3FFFFFFF), 32'(exp3[k]));
    end

    // Back-to-back: data request on fetch's ready cycle starts next cycle.
    drive(1'b1, 30'h500, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0, 32'd0);
    cyc();
    drive(1'b0, 30'd0, 1'b1, 1'b0, 30'h600, 32'd0, 1'b1, 32'hCAFE0001);
    settle();
    chk("t4_fetch_ready", 32'(f_rdy), 32'd1);
    adv();
    quiet();
    settle();
    chk("t4_data_start", 32'(b_start), 32'd1);
    chk("t4_data_addr", 32'(b_addr), 32'h600);
    adv();
    drive(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b1, 32'h0BADF00D);
    settle();
    chk("t4_data_ready", 32'(d_rdy), 32'd1);
    chk("t4_data_rd", d_rd, 32'h0BADF00D);
    adv();
    quiet();
    cyc();

    // Second fetch_start while fetch owns the bus is dropped.
    glog.delete();
    drive(1'b1, 30'h700, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0, 32'd0);
    cyc();
    drive(1'b1, 30'h704, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0, 32'd0);
    cyc();
    quiet();
    cyc();
    drive(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b1, 32'h33333333);
    settle();
    chk("t5_fetch_ready", 32'(f_rdy), 32'd1);
    adv();
    quiet();
    repeat (3) cyc();
    chk("t5_txn_count", 32'(glog.size()), 32'd1);
    chk("t5_txn_addr", 32'((glog.size() > 0) ? glog[0] : 30'h3FFFFFFF), 32'h700);
    // Spurious bus_ready with the bus idle.
    drive(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b1, 32'h44444444);
    settle();
    chk("t5_idle_fetch_ready", 32'(f_rdy), 32'd0);
    chk("t5_idle_data_ready", 32'(d_rdy), 32'd0);
    adv();
    quiet();
    cyc();

    // Asynchronous reset during a data grant with fetch waiting.
    drive(1'b1, 30'h900, 1'b1, 1'b1, 30'hA00, 32'h12345678, 1'b0, 32'd0);
    cyc();
    quiet();
    settle();
    br = 1'b1;
    rst = 1'b1;
    #1;
    chk("t6_rst_bus_start", 32'(b_start), 32'd0);
    chk("t6_rst_bus_write", 32'(b_write), 32'd0);
    chk("t6_rst_bus_addr", 32'(b_addr), 32'd0);
    chk("t6_rst_bus_data_wr", b_wdata, 32'd0);
    chk("t6_rst_fetch_ready", 32'(f_rdy), 32'd0);
    chk("t6_rst_data_ready", 32'(d_rdy), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b1, 32'h55555555);
    settle();
    chk("t6_post_fetch_ready", 32'(f_rdy), 32'd0);
    chk("t6_post_data_ready", 32'(d_rdy), 32'd0);
    adv();
    drive(1'b1, 30'h800, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0, 32'd0);
    cyc();
    quiet();
    settle();
    chk("t6_new_start", 32'(b_start), 32'd1);
    chk("t6_new_addr", 32'(b_addr), 32'h800);
    adv();
    drive(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b1, 32'h66666666);
    settle();
    chk("t6_new_ready", 32'(f_rdy), 32'd1);
    adv();
    quiet();
    cyc();

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      drive(1'($urandom_range(0, 1)), 30'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 30'($urandom), $urandom,
            1'($urandom_range(0, 1)), $urandom);
      cyc();
    end
    quiet();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
